sram_rw_client: RTL and testbench

- Requester-side controller for a single-port, 1-cycle-read-latency, masked-write SRAM macro; default geometry 32 x 148 with 2 mask lanes of 74 bits.
- Converts a valid/ready request stream (read or masked write) into the macro's RW port signals.
- Returns read data on a valid/ready response channel, with a 2-entry response buffer that absorbs backpressure.
- Sits between a pipeline client (cache/predictor table logic) and the generated SRAM wrapper.

---
 rtl/sram_rw_client.sv | 68 ++++++
 tb/tb_sram_rw_client.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_client.sv
// sram_rw_client: valid/ready front end for a 1-cycle-latency masked-write SRAM macro,
// returning read data through a 2-entry response buffer guarded by read credits.
module sram_rw_client #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 148,
    parameter int MASK_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    logic              s1_valid;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              empty;
    logic              enq;
    logic              deq;
    logic [DATA_W-1:0] fifo_q [2];

    // A read in flight holds a buffer slot, so the buffer can never overflow.
    assign req_ready  = (count + {1'b0, s1_valid}) < 2'd2;
    assign sram_en    = req_valid && req_ready;
    assign sram_wmode = req_write;
    assign sram_addr  = req_addr;
    assign sram_wmask = req_wmask;
    assign sram_wdata = req_wdata;

    assign empty      = count == 2'd0;
    assign resp_valid = s1_valid || !empty;
    assign resp_data  = empty ? sram_rdata : fifo_q[rd_ptr];
    assign deq        = !empty && resp_ready;
    assign enq        = s1_valid && !(empty && resp_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            s1_valid <= sram_en && !req_write;
            rd_ptr   <= rd_ptr ^ deq;
            wr_ptr   <= wr_ptr ^ enq;
            count    <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    always_ff @(posedge clock) begin
        if (enq) fifo_q[wr_ptr] <= sram_rdata;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(enq && count == 2'd2));
endmodule

// File: tb/tb_sram_rw_client.sv
// tb_sram_rw_client: directed stimulus against a behavioural SRAM, with a
// scoreboard queue filled at request accept and drained by a response monitor.
module tb_sram_rw_client;
    localparam int AW = 5;
    localparam int DW = 148;
    localparam int MW = 2;
    localparam int LW = 74;
    localparam logic [LW-1:0] D0H = 74'h1_1111_1111_1111_1111;
    localparam logic [LW-1:0] D0L = 74'h2_2222_2222_2222_2222;
    localparam logic [LW-1:0] D1L = 74'h3_0303_0303_0303_0303;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [MW-1:0] req_wmask;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_data;
    logic          sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata, sram_rdata;

    always #5 clock = ~clock;

    sram_rw_client #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    typedef struct { logic [DW-1:0] d; int c; } exp_t;
    exp_t          sb[$];
    exp_t          me;
    logic [DW-1:0] mem [32];
    logic [DW-1:0] ref_mem [32];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            chk_lat = 1'b0;

    function automatic logic [DW-1:0] pat(input int i);
        return {LW'(i) + LW'(256), LW'(i) ^ LW'(1023)};
    endfunction

    initial for (int i = 0; i < 32; i++) begin
        mem[i] = pat(i);
        ref_mem[i] = pat(i);
    end

    // Behavioural macro: 1-cycle read latency, per-lane write enables.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
            end else sram_rdata <= mem[sram_addr];
        end
    end

    always @(posedge clock) begin
        if (reset) sb.delete();
        else if (req_valid && req_ready) begin
            if (req_write) begin
                for (int l = 0; l < MW; l++)
                    if (req_wmask[l]) ref_mem[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
            end else sb.push_back('{ref_mem[req_addr], cyc});
        end
        cyc++;
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got %h expected no response", resp_data);
            end else begin
                me = sb.pop_front();
                chk("resp_order", resp_data, me.d);
                if (chk_lat) chk("resp_latency", DW'(cyc), DW'(me.c + 1));
            end
        end
    end

    // Call only just after a rising edge.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: req_ready low for 50 cycles at addr %0d", a);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (n == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wmask = '0; req_wdata = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_req_ready", req_ready, 1);
        step();
        // Full write then read of the same word, bypass path.
        chk_lat = 1'b1;
        issue(1'b1, 5'd3, 2'b11, {D0H, D0L});
        issue(1'b0, 5'd3, 2'b00, '0);
        @(negedge clock);
        chk("wr_rd_valid", resp_valid, 1);
        chk("wr_rd_data", resp_data, {D0H, D0L});
        step();
        chk_lat = 1'b0;
        // Low-lane-only write keeps the high lane.
        issue(1'b1, 5'd3, 2'b01, {D1L, D1L});
        issue(1'b0, 5'd3, 2'b00, '0);
        @(negedge clock);
        chk("mask_data", resp_data, {D0H, D1L});
        step();
        // Read 5, then overwrite 5 while the response is stalled.
        resp_ready = 1'b0;
        issue(1'b0, 5'd5, 2'b00, '0);
        issue(1'b1, 5'd5, 2'b11, {D1L, D1L});
        repeat (2) step();
        resp_ready = 1'b1;
        @(negedge clock);
        chk("hazard_valid", resp_valid, 1);
        chk("hazard_old", resp_data, {74'h105, 74'h3FA});
        step();
        issue(1'b0, 5'd5, 2'b00, '0);
        @(negedge clock);
        chk("hazard_new", resp_data, {D1L, D1L});
        step();
        drain();
        // Stall: only two reads get in.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd0;
        @(negedge clock);
        chk("stall_ready0", req_ready, 1);
        step();
        req_addr = 5'd1;
        @(negedge clock);
        chk("stall_ready1", req_ready, 1);
        step();
        req_addr = 5'd2;
        @(negedge clock);
        chk("stall_ready2", req_ready, 0);
        step();
        @(negedge clock);
        chk("stall_ready3", req_ready, 0);
        chk("stall_head", resp_data, {74'h100, 74'h3FF});
        step();
        resp_ready = 1'b1;
        issue(1'b0, 5'd2, 2'b00, '0);
        issue(1'b0, 5'd3, 2'b00, '0);
        drain();
        // Back-to-back reads at full rate.
        chk_lat = 1'b1;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(i);
            @(negedge clock);
            chk("b2b_ready", req_ready, 1);
            step();
        end
        req_valid = 1'b0;
        drain();
        chk_lat = 1'b0;
        // Reset with a buffered response and a read in flight.
        resp_ready = 1'b0;
        issue(1'b0, 5'd0, 2'b00, '0);
        issue(1'b0, 5'd1, 2'b00, '0);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("postrst_resp_valid", resp_valid, 0);
        chk("postrst_req_ready", req_ready, 1);
        chk("postrst_sram_en", sram_en, 0);
        step();
        resp_ready = 1'b1;
        issue(1'b0, 5'd4, 2'b00, '0);
        @(negedge clock);
        chk("postrst_read", resp_data, {74'h104, 74'h3FB});
        step();
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at 20000, expected finish");
        $fatal(1);
    end
endmodule
